// File: rtl/hack_cpu_pkg.sv
// Shared types and instruction-field constants for the multi-cycle Hack CPU.
// Holds the FSM state enum, C-instruction field positions and jump codes.
package hack_cpu_pkg;

    typedef enum logic [2:0] {
        S_FETCH,
        S_EXEC,
        S_MRD,
        S_MWR,
        S_HALT
    } state_t;

    localparam int A_BIT    = 12;
    localparam int COMP_LSB = 6;
    localparam int DEST_LSB = 3;
    localparam int JUMP_LSB = 0;

    localparam int DEST_M = 0;
    localparam int DEST_D = 1;
    localparam int DEST_A = 2;

    localparam logic [2:0] JGT = 3'd1;
    localparam logic [2:0] JEQ = 3'd2;
    localparam logic [2:0] JGE = 3'd3;
    localparam logic [2:0] JLT = 3'd4;
    localparam logic [2:0] JNE = 3'd5;
    localparam logic [2:0] JLE = 3'd6;
    localparam logic [2:0] JMP = 3'd7;

    function automatic logic jump_take(
        input logic [2:0] j,
        input logic       zr,
        input logic       ng
    );
        return (j[2] & ng) | (j[1] & zr) | (j[0] & ~ng & ~zr);
    endfunction

endpackage

// File: rtl/hack_cpu_mc_alu.sv
// Combinational Hack ALU (zx/nx/zy/ny/f/no) at a parametrised width.
// Flags: zr when the result is zero, ng from the result sign bit.
module hack_alu
    import hack_cpu_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] y,
    input  logic [5:0]        c,
    output logic [DATA_W-1:0] out,
    output logic              zr,
    output logic              ng
);
    logic [DATA_W-1:0] xz, xn, yz, yn, f;

    assign xz  = c[5] ? '0 : x;
    assign xn  = c[4] ? ~xz : xz;
    assign yz  = c[3] ? '0 : y;
    assign yn  = c[2] ? ~yz : yz;
    assign f   = c[1] ? (xn + yn) : (xn & yn);
    assign out = c[0] ? ~f : f;
    assign zr  = (out == '0);
    assign ng  = out[DATA_W-1];

endmodule

// File: rtl/hack_cpu_mc.sv
// Multi-cycle Hack CPU with handshaked instruction and data memories.
// Adds read-modify-write of M, a self-loop halt flag and a retire pulse.
module hack_cpu_mc
    import hack_cpu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_valid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ready,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic              retire
);
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] d_q, d_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] m_q, m_d;
    logic              halted_q, halted_d;

    logic              is_c, sel_m, take, self_loop, commit;
    logic [5:0]        comp;
    logic [2:0]        dest, jmp;
    logic [DATA_W-1:0] alu_y, alu_out;
    logic              alu_zr, alu_ng;
    logic [ADDR_W-1:0] pc_inc, target;

    assign is_c   = ir_q[DATA_W-1];
    assign sel_m  = ir_q[A_BIT];
    assign comp   = ir_q[COMP_LSB +: 6];
    assign dest   = ir_q[DEST_LSB +: 3];
    assign jmp    = ir_q[JUMP_LSB +: 3];
    assign pc_inc = pc_q + ADDR_W'(1);
    assign target = a_q[ADDR_W-1:0];

    // M bypasses its latch in the cycle the read completes
    assign alu_y = !sel_m ? a_q :
                   (state_q == S_MRD) ? dmem_rdata : m_q;

    hack_alu #(.DATA_W(DATA_W)) u_alu (
        .x   (d_q),
        .y   (alu_y),
        .c   (comp),
        .out (alu_out),
        .zr  (alu_zr),
        .ng  (alu_ng)
    );

    assign take      = jump_take(jmp, alu_zr, alu_ng);
    assign self_loop = is_c && take && (target == pc_q);

    always_comb begin
        commit = 1'b0;
        unique case (state_q)
            S_EXEC:  commit = !is_c || (!sel_m && !dest[DEST_M]);
            S_MRD:   commit = dmem_ready && !dest[DEST_M];
            S_MWR:   commit = dmem_ready;
            default: commit = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH: if (imem_valid) state_d = S_EXEC;
            S_EXEC: begin
                if (is_c && sel_m)            state_d = S_MRD;
                else if (is_c && dest[DEST_M]) state_d = S_MWR;
            end
            S_MRD: if (dmem_ready && dest[DEST_M]) state_d = S_MWR;
            default: state_d = state_q;
        endcase
        if (commit) state_d = self_loop ? S_HALT : S_FETCH;
    end

    always_comb begin
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        unique case (state_q)
            S_FETCH: imem_req = reset;
            S_MRD:   dmem_req = reset;
            S_MWR: begin
                dmem_req = reset;
                dmem_we  = 1'b1;
            end
            default: imem_req = 1'b0;
        endcase
        retire = reset && commit;
    end

    always_comb begin
        pc_d     = pc_q;
        a_d      = a_q;
        d_d      = d_q;
        ir_d     = ir_q;
        m_d      = m_q;
        halted_d = halted_q;
        if (state_q == S_FETCH && imem_valid) ir_d = imem_rdata;
        if (state_q == S_MRD && dmem_ready)   m_d  = dmem_rdata;
        if (commit) begin
            if (!is_c) begin
                a_d  = {1'b0, ir_q[DATA_W-2:0]};
                pc_d = pc_inc;
            end else begin
                if (dest[DEST_A]) a_d = alu_out;
                if (dest[DEST_D]) d_d = alu_out;
                pc_d = take ? target : pc_inc;
                if (self_loop) halted_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q     <= '0;
            a_q      <= '0;
            d_q      <= '0;
            ir_q     <= '0;
            m_q      <= '0;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            a_q      <= a_d;
            d_q      <= d_d;
            ir_q     <= ir_d;
            m_q      <= m_d;
            halted_q <= halted_d;
        end
    end

    assign imem_addr  = pc_q;
    assign dmem_addr  = a_q[ADDR_W-1:0];
    assign dmem_wdata = alu_out;
    assign pc         = pc_q;
    assign halted     = halted_q;

endmodule

// File: tb/tb_hack_cpu_mc.sv
// Self-checking bench for hack_cpu_mc: ISA-level model plus directed checks.
// Covers a 16-bit core with wait-state memories and a 32/24-bit instance.
module tb_hack_cpu_mc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    // ---------------- 16-bit instance ----------------
    logic        rst = 1'b0;
    logic        n_imem_req, n_imem_valid;
    logic [14:0] n_imem_addr, n_dmem_addr, n_pc;
    logic [15:0] n_imem_rdata, n_dmem_wdata, n_dmem_rdata;
    logic        n_dmem_req, n_dmem_we, n_dmem_ready;
    logic        n_halted, n_retire;

    logic [15:0] prog [0:31];
    logic [15:0] mem  [0:2047];
    int ilat = 0, dlat = 3;
    int icnt = 0, dcnt = 0;

    assign n_imem_valid = n_imem_req && (icnt >= ilat);
    assign n_imem_rdata = prog[n_imem_addr[4:0]];
    assign n_dmem_ready = n_dmem_req && (dcnt >= dlat);
    assign n_dmem_rdata = mem[n_dmem_addr[10:0]];

    always @(posedge clk) begin
        icnt <= (n_imem_req && !n_imem_valid) ? icnt + 1 : 0;
        dcnt <= (n_dmem_req && !n_dmem_ready) ? dcnt + 1 : 0;
        if (n_dmem_req && n_dmem_we && n_dmem_ready)
            mem[n_dmem_addr[10:0]] <= n_dmem_wdata;
    end

    hack_cpu_mc #(.DATA_W(16), .ADDR_W(15)) dut_n (
        .clk(clk), .reset(rst),
        .imem_req(n_imem_req), .imem_addr(n_imem_addr),
        .imem_valid(n_imem_valid), .imem_rdata(n_imem_rdata),
        .dmem_req(n_dmem_req), .dmem_we(n_dmem_we),
        .dmem_addr(n_dmem_addr), .dmem_wdata(n_dmem_wdata),
        .dmem_rdata(n_dmem_rdata), .dmem_ready(n_dmem_ready),
        .pc(n_pc), .halted(n_halted), .retire(n_retire)
    );

    // ---------------- 32/24-bit instance ----------------
    logic        wrst = 1'b0;
    logic        w_rdy = 1'b0;
    logic        w_imem_req, w_imem_valid;
    logic [23:0] w_imem_addr, w_dmem_addr, w_pc;
    logic [31:0] w_imem_rdata, w_dmem_wdata, w_dmem_rdata;
    logic        w_dmem_req, w_dmem_we, w_dmem_ready;
    logic        w_halted, w_retire;
    logic [31:0] wprog [0:3];

    assign w_imem_valid = w_imem_req;
    assign w_imem_rdata = (w_imem_addr == 24'hFFFFFF) ? 32'd5
                                                      : wprog[w_imem_addr[1:0]];
    assign w_dmem_ready = w_dmem_req && w_rdy;
    assign w_dmem_rdata = 32'd0;

    hack_cpu_mc #(.DATA_W(32), .ADDR_W(24)) dut_w (
        .clk(clk), .reset(wrst),
        .imem_req(w_imem_req), .imem_addr(w_imem_addr),
        .imem_valid(w_imem_valid), .imem_rdata(w_imem_rdata),
        .dmem_req(w_dmem_req), .dmem_we(w_dmem_we),
        .dmem_addr(w_dmem_addr), .dmem_wdata(w_dmem_wdata),
        .dmem_rdata(w_dmem_rdata), .dmem_ready(w_dmem_ready),
        .pc(w_pc), .halted(w_halted), .retire(w_retire)
    );

    // ---------------- ISA-level model ----------------
    logic [14:0] m_pc;
    logic [15:0] m_a, m_d;
    logic        m_halt;
    logic [15:0] mmem [0:2047];
    logic        m_armed = 1'b0, rst_pend = 1'b0;
    int          nret = 0, run = 0, wr_run0 = 0;
    logic        fetched [0:31];

    function automatic logic [16:0] hack_op(input logic [5:0] c,
                                            input logic [15:0] x,
                                            input logic [15:0] y);
        case (c)
            6'h2A: return {1'b1, 16'd0};
            6'h3F: return {1'b1, 16'd1};
            6'h3A: return {1'b1, 16'hFFFF};
            6'h0C: return {1'b1, x};
            6'h30: return {1'b1, y};
            6'h0D: return {1'b1, ~x};
            6'h31: return {1'b1, ~y};
            6'h0F: return {1'b1, 16'd0 - x};
            6'h33: return {1'b1, 16'd0 - y};
            6'h1F: return {1'b1, x + 16'd1};
            6'h37: return {1'b1, y + 16'd1};
            6'h0E: return {1'b1, x - 16'd1};
            6'h32: return {1'b1, y - 16'd1};
            6'h02: return {1'b1, x + y};
            6'h13: return {1'b1, x - y};
            6'h07: return {1'b1, y - x};
            6'h00: return {1'b1, x & y};
            6'h15: return {1'b1, x | y};
            default: return 17'd0;
        endcase
    endfunction

    function automatic logic jmodel(input logic [2:0] j,
                                    input logic signed [15:0] v);
        case (j)
            3'd0: return 1'b0;
            3'd1: return v > 0;
            3'd2: return v == 0;
            3'd3: return v >= 0;
            3'd4: return v < 0;
            3'd5: return v != 0;
            3'd6: return v <= 0;
            default: return 1'b1;
        endcase
    endfunction

    task automatic model_eval(input logic commit);
        logic [15:0] ins, y, r;
        logic [16:0] o;
        logic        is_c, wm, tk;
        logic [14:0] tgt;
        ins  = prog[m_pc[4:0]];
        is_c = ins[15];
        y    = ins[12] ? mmem[m_a[10:0]] : m_a;
        o    = hack_op(ins[11:6], m_d, y);
        r    = o[15:0];
        wm   = is_c && ins[3];
        tk   = is_c && jmodel(ins[2:0], r);
        tgt  = m_a[14:0];
        if (n_dmem_req && n_dmem_we) begin
            chk("wr_expected", wm, 1);
            chk("wr_addr", n_dmem_addr, m_a[14:0]);
            chk("wr_data", n_dmem_wdata, r);
        end
        if (n_dmem_req && !n_dmem_we)
            chk("rd_expected", is_c && ins[12], 1);
        if (commit) begin
            if (is_c) chk("comp_known", o[16], 1);
            chk("wr_at_retire", n_dmem_req && n_dmem_we && n_dmem_ready, wm);
            if (!is_c) begin
                m_a  = {1'b0, ins[14:0]};
                m_pc = m_pc + 15'd1;
            end else begin
                if (wm) mmem[m_a[10:0]] = r;
                if (tk && tgt == m_pc) m_halt = 1'b1;
                m_pc = tk ? tgt : m_pc + 15'd1;
                if (ins[5]) m_a = r;
                if (ins[4]) m_d = r;
            end
        end
    endtask

    // Compare process: one pass per cycle, away from the rising edge
    always @(negedge clk) begin
        if (rst_pend) begin
            m_pc = '0; m_a = '0; m_d = '0; m_halt = 1'b0;
            m_armed = 1'b1;
        end
        if (m_armed) begin
            chk("pc", n_pc, m_pc);
            chk("imem_addr", n_imem_addr, m_pc);
            chk("dmem_addr", n_dmem_addr, m_a[14:0]);
            chk("halted", n_halted, m_halt);
            if (!rst) begin
                chk("rst_imem_req", n_imem_req, 0);
                chk("rst_dmem_req", n_dmem_req, 0);
                chk("rst_retire", n_retire, 0);
            end else if (m_halt) begin
                chk("halt_imem_req", n_imem_req, 0);
                chk("halt_dmem_req", n_dmem_req, 0);
                chk("halt_retire", n_retire, 0);
            end else begin
                model_eval(n_retire);
            end
        end
        if (rst && n_retire) nret++;
        if (n_dmem_req && n_dmem_we) run++;
        else begin
            if (run > 0 && wr_run0 == 0) wr_run0 = run;
            run = 0;
        end
        if (n_imem_req && n_imem_valid) fetched[n_imem_addr[4:0]] = 1'b1;
        rst_pend = !rst;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: no finish, required finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 2048; i++) begin
            mem[i] = 16'd0;
            mmem[i] = 16'd0;
        end
        for (int i = 0; i < 32; i++) begin
            prog[i] = 16'd0;
            fetched[i] = 1'b0;
        end
        mem[1001] = 16'd41; mmem[1001] = 16'd41;
        prog[0]  = 16'h3039;  // @12345
        prog[1]  = 16'hEC10;  // D=A
        prog[2]  = 16'h03E8;  // @1000
        prog[3]  = 16'hE308;  // M=D
        prog[4]  = 16'h03E9;  // @1001
        prog[5]  = 16'hFDC8;  // M=M+1
        prog[6]  = 16'hEE90;  // D=-1
        prog[7]  = 16'h000E;  // @14
        prog[8]  = 16'hE304;  // D;JLT
        prog[14] = 16'hEA90;  // D=0
        prog[15] = 16'h0014;  // @20
        prog[16] = 16'hE301;  // D;JGT
        prog[17] = 16'hE302;  // D;JEQ
        prog[20] = 16'h0018;  // @24
        prog[21] = 16'hE305;  // D;JNE
        prog[22] = 16'hE307;  // D;JMP
        prog[24] = 16'h0019;  // @25
        prog[25] = 16'hEA87;  // 0;JMP
        wprog[0] = 32'h7FFFFFFF;
        wprog[1] = 32'hFFFFE308;
        wprog[2] = 32'd0;
        wprog[3] = 32'd0;

        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("first_retire_low", n_retire, 0);
        chk("first_imem_req", n_imem_req, 1);
        chk("first_imem_addr", n_imem_addr, 15'd0);
        @(negedge clk);
        chk("first_retire", n_retire, 1);
        @(negedge clk);
        chk("pc_after_a", n_pc, 15'd1);
        chk("a_after_a", n_dmem_addr, 15'd12345);
        ilat = 1;

        for (int i = 0; i < 400; i++) begin
            if (n_halted) break;
            @(negedge clk);
        end
        chk("halt_reached", n_halted, 1);
        chk("halt_pc", n_pc, 15'd25);
        chk("halt_a", n_dmem_addr, 15'd25);
        chk("mem1000", mem[1000], 16'd12345);
        chk("mem1001", mem[1001], 16'd42);
        chk("retire_count", nret, 18);
        chk("mwr_hold_cycles", wr_run0, 4);
        chk("jlt_target", fetched[14], 1);
        chk("jlt_skipped", fetched[9], 0);
        chk("jeq_skipped", fetched[18], 0);
        chk("jmp_skipped", fetched[23], 0);
        repeat (5) @(negedge clk);
        chk("still_halted", n_halted, 1);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_pc", n_pc, 15'd0);
        chk("rst_halted", n_halted, 0);

        @(posedge clk);
        #1 wrst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (w_dmem_req && w_dmem_we) break;
            @(negedge clk);
        end
        chk("w_mwr_seen", w_dmem_req && w_dmem_we, 1);
        chk("w_dmem_addr", w_dmem_addr, 24'hFFFFFF);
        chk("w_wdata", w_dmem_wdata, 32'd0);
        chk("w_pc_wait", w_pc, 24'd1);
        @(posedge clk);
        #1 wrst = 1'b0;
        wprog[1] = 32'hFFFFEA87;
        w_rdy = 1'b1;
        @(negedge clk);
        chk("w_req_in_rst", w_dmem_req, 0);
        @(posedge clk);
        #1 wrst = 1'b1;
        @(negedge clk);
        chk("w_req_after_rst", w_dmem_req, 0);
        chk("w_pc_rst", w_pc, 24'd0);
        chk("w_fetch_rst", w_imem_req, 1);
        for (int i = 0; i < 20; i++) begin
            if (w_pc == 24'hFFFFFF) break;
            @(negedge clk);
        end
        chk("w_pc_top", w_pc, 24'hFFFFFF);
        chk("w_a_low", w_dmem_addr, 24'hFFFFFF);
        chk("w_not_halted", w_halted, 0);
        for (int i = 0; i < 20; i++) begin
            if (w_pc != 24'hFFFFFF) break;
            @(negedge clk);
        end
        chk("w_pc_wrap", w_pc, 24'd0);
        chk("w_a_after_wrap", w_dmem_addr, 24'd5);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
